ide_xfer_ctrl: RTL and testbench
================================

Name: ide_xfer_ctrl

Overview:
Sector-transfer sequencer that drives the ide register bus (ce_n/oe_n/we_n/address/data) on behalf of one requester. Given a 24-bit LBA and a direction, it programs the task file, issues the command, polls status, then moves one 512-byte sector between the ide data register and a local byte buffer. It sits between the CPU/DMA side and the ide device model, replacing hand-coded register bit-banging.

Parameters:
STROBE_CYCLES, 2, cycles oe_n/we_n are held low per register access (min 1)
POLL_TIMEOUT, 1024, max status reads before the block aborts with error
SECTOR_BYTES, 512, bytes moved per command (power of two, at most 512)

Ports:
clk  in  1  system clock, all logic on rising edge
arst  in  1  reset; synchronous, active-high, sampled only on clk rising edge
req_valid  in  1  transfer request
req_ready  out  1  high in IDLE only; request accepted when valid&&ready
req_write  in  1  1 = buffer->disk (cmd 0x30), 0 = disk->buffer (cmd 0x20)
req_lba  in  24  sector LBA, captured at accept
buf_addr  out  9  local buffer byte address
buf_we  out  1  buffer write strobe (read direction)
buf_wdata  out  8  buffer write data
buf_rdata  in  8  buffer read data, 1-cycle synchronous latency from buf_addr
ide_ce_n  out  1  ide chip enable, active low
ide_oe_n  out  1  ide read strobe, active low
ide_we_n  out  1  ide write strobe, active low
ide_address  out  3  ide register index
ide_data_out  out  8  data to ide
ide_data_in  in  8  data from ide
busy  out  1  high from accept until DONE/ERROR is left
done  out  1  one-cycle pulse on successful completion
error  out  1  sticky; set on ERR status or timeout, cleared at next accept
last_status  out  8  last value read from register 7

Behaviour:
- Reset: state IDLE; req_ready=1; busy=done=error=0; ide_ce_n=ide_oe_n=ide_we_n=1; ide_address=0; ide_data_out=0; buf_we=0; buf_addr=0; last_status=0; counters 0. Reset mid-transfer aborts on the same edge with no done pulse; strobes are high on the next cycle.
- Bus access primitive, STROBE_CYCLES+2 cycles: SETUP (ce_n=0, address/data valid, strobes high), STROBE x N (oe_n or we_n low), HOLD (strobes high, ce_n=0). Read data is captured on the last STROBE cycle. ce_n returns high for 1 idle cycle between accesses. address and data are stable for the whole access.
- States:
  - IDLE: on accept, latch lba/write, clear error -> TASKFILE.
  - TASKFILE: writes reg2=0x01, reg3=lba[7:0], reg4=lba[15:8], reg5=lba[23:16], reg6=0xE0, in that order -> CMD.
  - CMD: writes reg7 = 0x30 if write, else 0x20 -> POLL.
  - POLL: reads reg7 into last_status.
    - bit0 (ERR) set -> ERROR. ERR has priority over DRQ.
    - Else bit7 (BSY)=0 and bit3 (DRQ)=1 -> XFER.
    - Else repeat. After POLL_TIMEOUT reads without exit -> ERROR.
  - XFER: SECTOR_BYTES accesses to reg0, byte counter 0..SECTOR_BYTES-1, buf_addr = counter.
    - Read: byte written to buffer via buf_we for 1 cycle in the HOLD cycle.
    - Write: buf_addr is presented in the idle cycle before SETUP; buf_rdata drives ide_data_out from SETUP on.
    - After the last byte -> DONE. The counter does not wrap into a further access.
  - DONE: done=1 for 1 cycle, busy drops -> IDLE.
  - ERROR: error=1 (sticky), busy drops -> IDLE.
- req_valid while busy is ignored (req_ready=0); no queuing.
- Command byte values and register indices are fixed constants.

Decomposition:
- Package ide_pkg holds:
  - register indices (DATA=0, ERR=1, SECCNT=2, LBA0..2=3..5, DRVHEAD=6, CMD_STATUS=7)
  - command constants (CMD_READ=0x20, CMD_WRITE=0x30)
  - status bit positions (BSY=7, DRQ=3, ERR=0)
  - typedef enum for controller states
- One sub-module, ide_bus_access: executes a single read/write access with start/done handshake, owns the strobe timing and STROBE_CYCLES. The top FSM sequences it.

Test Plan:
- Read, lba=0x000102, model returns status 0x08 then bytes 1..512 -> task file writes 01,02,01,00,E0 to regs 2..6, 0x20 to reg7; buffer[0]=0x01, buffer[511]=0x00 (byte 512 truncated to 8 bits); one done pulse.
- Write, buffer filled with 0xA5^addr -> reg0 receives 512 bytes in address order; first byte 0xA5, last 0x5A; cmd 0x30.
- Status 0x80 for 3 polls then 0x08 -> exactly 4 reg7 reads, then XFER; last_status=0x08.
- Status 0x09 on the first poll -> ERROR, error=1, no reg0 access, no done pulse; next accept clears error.
- Status stuck at 0x80 with POLL_TIMEOUT=4 -> exactly 4 polls, then error=1, busy=0.
- arst asserted at byte 100 of XFER -> next cycle all strobes high, busy=0, req_ready=1; a new request completes normally; strobe low width equals STROBE_CYCLES on every access.

Source files
------------

// File: rtl/ide_pkg.sv
// ide_pkg: shared constants and types for the IDE sector-transfer controller.
//   - ide register indices, command bytes, status bit positions
//   - controller and bus-access state enums, debug struct
//   - taskfile_byte(): data byte for each of the five task-file writes
package ide_pkg;

    localparam logic [2:0] REG_DATA       = 3'd0;
    localparam logic [2:0] REG_ERR        = 3'd1;
    localparam logic [2:0] REG_SECCNT     = 3'd2;
    localparam logic [2:0] REG_LBA0       = 3'd3;
    localparam logic [2:0] REG_LBA1       = 3'd4;
    localparam logic [2:0] REG_LBA2       = 3'd5;
    localparam logic [2:0] REG_DRVHEAD    = 3'd6;
    localparam logic [2:0] REG_CMD_STATUS = 3'd7;

    localparam logic [7:0] CMD_READ    = 8'h20;
    localparam logic [7:0] CMD_WRITE   = 8'h30;
    localparam logic [7:0] SECCNT_ONE  = 8'h01;
    localparam logic [7:0] DRVHEAD_LBA = 8'hE0;

    localparam int ST_BSY = 7;
    localparam int ST_DRQ = 3;
    localparam int ST_ERR = 0;

    typedef enum logic [2:0] {
        S_IDLE, S_TASKFILE, S_CMD, S_POLL, S_XFER, S_DONE, S_ERROR
    } ide_state_e;

    typedef enum logic [1:0] {
        B_IDLE, B_SETUP, B_STROBE, B_HOLD
    } bus_state_e;

    typedef struct packed {
        ide_state_e ctrl;
        bus_state_e bus;
    } ide_dbg_t;

    // Task-file write idx (0..4) targets register REG_SECCNT + idx.
    function automatic logic [7:0] taskfile_byte(input logic [2:0] idx, input logic [23:0] lba);
        case (idx)
            3'd0:    return SECCNT_ONE;
            3'd1:    return lba[7:0];
            3'd2:    return lba[15:8];
            3'd3:    return lba[23:16];
            default: return DRVHEAD_LBA;
        endcase
    endfunction

endpackage

// File: rtl/ide_bus_access.sv
// ide_bus_access: performs one ide register read or write.
//   start/is_write/addr : request, taken only while the bus is idle
//   wdata               : write data, followed live for the whole access
//   ide_*               : ide register bus (active-low ce/oe/we)
//   rdata               : byte captured on the last strobe cycle
//   done                : one-cycle pulse during HOLD
//   dbg_state           : current access phase
// Handshake: start is a single-cycle pulse issued while the bus is idle; done
// pulses in HOLD so the caller can issue the next start in the following
// cycle, which leaves exactly one ce_n-high cycle between accesses.
module ide_bus_access
    import ide_pkg::*;
#(
    parameter int STROBE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       start,
    input  logic       is_write,
    input  logic [2:0] addr,
    input  logic [7:0] wdata,
    input  logic [7:0] ide_data_in,
    output logic       ide_ce_n,
    output logic       ide_oe_n,
    output logic       ide_we_n,
    output logic [2:0] ide_address,
    output logic [7:0] ide_data_out,
    output logic [7:0] rdata,
    output logic       done,
    output bus_state_e dbg_state
);

    localparam int CW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
    localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_CYCLES - 1);

    bus_state_e    state_q, state_d;
    logic          ce_n_q, ce_n_d;
    logic          oe_n_q, oe_n_d;
    logic          we_n_q, we_n_d;
    logic [2:0]    addr_q, addr_d;
    logic          write_q, write_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          done_q, done_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        ce_n_d  = ce_n_q;
        oe_n_d  = oe_n_q;
        we_n_d  = we_n_q;
        addr_d  = addr_q;
        write_d = write_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            B_IDLE: begin
                if (start) begin
                    state_d = B_SETUP;
                    ce_n_d  = 1'b0;
                    addr_d  = addr;
                    write_d = is_write;
                    cnt_d   = '0;
                end
            end
            B_SETUP: begin
                state_d = B_STROBE;
                oe_n_d  = write_q;
                we_n_d  = ~write_q;
            end
            B_STROBE: begin
                if (cnt_q == STROBE_LAST) begin
                    if (!write_q) begin
                        rdata_d = ide_data_in;
                    end
                    oe_n_d  = 1'b1;
                    we_n_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = B_HOLD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            B_HOLD: begin
                ce_n_d  = 1'b1;
                state_d = B_IDLE;
            end
            default: state_d = B_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state_q <= B_IDLE;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            addr_q  <= 3'd0;
            write_q <= 1'b0;
            rdata_q <= 8'h00;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ide_ce_n     = ce_n_q;
    assign ide_oe_n     = oe_n_q;
    assign ide_we_n     = we_n_q;
    assign ide_address  = addr_q;
    // wdata is followed live so buffer data arriving in SETUP reaches the bus.
    assign ide_data_out = (state_q != B_IDLE && write_q) ? wdata : 8'h00;
    assign rdata        = rdata_q;
    assign done         = done_q;
    assign dbg_state    = state_q;

endmodule

// File: rtl/ide_xfer_ctrl.sv
// ide_xfer_ctrl: programs the ide task file, issues a read/write sector
// command, polls status and moves one sector between ide reg0 and a local
// byte buffer.
//   req_valid/req_ready/req_write/req_lba : request port
//   buf_addr/buf_we/buf_wdata/buf_rdata   : local buffer (1-cycle read latency)
//   ide_*                                 : ide register bus
//   busy/done/error/last_status           : status
//   dbg                                   : controller and bus-access states
// Handshake: a request is taken on a rising edge where req_valid && req_ready;
// req_ready is high only in IDLE, so requests during a transfer are ignored.
module ide_xfer_ctrl
    import ide_pkg::*;
#(
    parameter int STROBE_CYCLES = 2,
    parameter int POLL_TIMEOUT  = 1024,
    parameter int SECTOR_BYTES  = 512
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [23:0] req_lba,
    output logic [8:0]  buf_addr,
    output logic        buf_we,
    output logic [7:0]  buf_wdata,
    input  logic [7:0]  buf_rdata,
    output logic        ide_ce_n,
    output logic        ide_oe_n,
    output logic        ide_we_n,
    output logic [2:0]  ide_address,
    output logic [7:0]  ide_data_out,
    input  logic [7:0]  ide_data_in,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  last_status,
    output ide_dbg_t    dbg
);

    localparam int PW = $clog2(POLL_TIMEOUT) + 1;
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_TIMEOUT - 1);
    localparam logic [8:0]    BYTE_LAST = 9'(SECTOR_BYTES - 1);

    ide_state_e    state_q, state_d;
    logic [23:0]   lba_q, lba_d;
    logic          write_q, write_d;
    logic [2:0]    tf_idx_q, tf_idx_d;
    logic [PW-1:0] poll_cnt_q, poll_cnt_d;
    logic [8:0]    byte_cnt_q, byte_cnt_d;
    logic          start_q, start_d;
    logic          acc_write_q, acc_write_d;
    logic [2:0]    acc_addr_q, acc_addr_d;
    logic [7:0]    acc_data_q, acc_data_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic [7:0]    status_q, status_d;

    logic          acc_done;
    logic [7:0]    acc_rdata;
    logic [7:0]    acc_wdata;
    bus_state_e    bus_state;

    // Sector writes take data straight from the buffer read port.
    assign acc_wdata = (state_q == S_XFER) ? buf_rdata : acc_data_q;

    ide_bus_access #(.STROBE_CYCLES(STROBE_CYCLES)) u_bus (
        .clk          (clk),
        .arst         (arst),
        .start        (start_q),
        .is_write     (acc_write_q),
        .addr         (acc_addr_q),
        .wdata        (acc_wdata),
        .ide_data_in  (ide_data_in),
        .ide_ce_n     (ide_ce_n),
        .ide_oe_n     (ide_oe_n),
        .ide_we_n     (ide_we_n),
        .ide_address  (ide_address),
        .ide_data_out (ide_data_out),
        .rdata        (acc_rdata),
        .done         (acc_done),
        .dbg_state    (bus_state)
    );

    always_comb begin
        state_d     = state_q;
        lba_d       = lba_q;
        write_d     = write_q;
        tf_idx_d    = tf_idx_q;
        poll_cnt_d  = poll_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        start_d     = 1'b0;
        acc_write_d = acc_write_q;
        acc_addr_d  = acc_addr_q;
        acc_data_d  = acc_data_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = error_q;
        status_d    = status_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    lba_d       = req_lba;
                    write_d     = req_write;
                    error_d     = 1'b0;
                    busy_d      = 1'b1;
                    tf_idx_d    = 3'd0;
                    start_d     = 1'b1;
                    acc_write_d = 1'b1;
                    acc_addr_d  = REG_SECCNT;
                    acc_data_d  = taskfile_byte(3'd0, req_lba);
                    state_d     = S_TASKFILE;
                end
            end
            S_TASKFILE: begin
                if (acc_done) begin
                    start_d     = 1'b1;
                    acc_write_d = 1'b1;
                    if (tf_idx_q == 3'd4) begin
                        acc_addr_d = REG_CMD_STATUS;
                        acc_data_d = write_q ? CMD_WRITE : CMD_READ;
                        state_d    = S_CMD;
                    end else begin
                        // Next write idx+1 lands on register idx+3.
                        tf_idx_d   = tf_idx_q + 3'd1;
                        acc_addr_d = tf_idx_q + 3'd3;
                        acc_data_d = taskfile_byte(tf_idx_q + 3'd1, lba_q);
                    end
                end
            end
            S_CMD: begin
                if (acc_done) begin
                    poll_cnt_d  = '0;
                    start_d     = 1'b1;
                    acc_write_d = 1'b0;
                    acc_addr_d  = REG_CMD_STATUS;
                    state_d     = S_POLL;
                end
            end
            S_POLL: begin
                if (acc_done) begin
                    status_d = acc_rdata;
                    if (acc_rdata[ST_ERR]) begin
                        error_d = 1'b1;
                        state_d = S_ERROR;
                    end else if (!acc_rdata[ST_BSY] && acc_rdata[ST_DRQ]) begin
                        byte_cnt_d  = 9'd0;
                        start_d     = 1'b1;
                        acc_write_d = write_q;
                        acc_addr_d  = REG_DATA;
                        state_d     = S_XFER;
                    end else if (poll_cnt_q == POLL_LAST) begin
                        error_d = 1'b1;
                        state_d = S_ERROR;
                    end else begin
                        poll_cnt_d = poll_cnt_q + PW'(1);
                        start_d    = 1'b1;
                    end
                end
            end
            S_XFER: begin
                if (acc_done) begin
                    if (byte_cnt_q == BYTE_LAST) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 9'd1;
                        start_d    = 1'b1;
                    end
                end
            end
            S_DONE, S_ERROR: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state_q     <= S_IDLE;
            lba_q       <= 24'd0;
            write_q     <= 1'b0;
            tf_idx_q    <= 3'd0;
            poll_cnt_q  <= '0;
            byte_cnt_q  <= 9'd0;
            start_q     <= 1'b0;
            acc_write_q <= 1'b0;
            acc_addr_q  <= 3'd0;
            acc_data_q  <= 8'h00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            status_q    <= 8'h00;
        end else begin
            state_q     <= state_d;
            lba_q       <= lba_d;
            write_q     <= write_d;
            tf_idx_q    <= tf_idx_d;
            poll_cnt_q  <= poll_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            start_q     <= start_d;
            acc_write_q <= acc_write_d;
            acc_addr_q  <= acc_addr_d;
            acc_data_q  <= acc_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            status_q    <= status_d;
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign buf_addr    = byte_cnt_q;
    // Read bytes land in the buffer during the HOLD cycle of each reg0 read.
    assign buf_we      = (state_q == S_XFER) && !write_q && acc_done;
    assign buf_wdata   = acc_rdata;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign last_status = status_q;
    assign dbg.ctrl    = state_q;
    assign dbg.bus     = bus_state;

endmodule

// File: tb/tb_ide_xfer_ctrl.sv
// Directed bench for ide_xfer_ctrl with an ide register model, a local
// buffer model and a scoreboard of expected ide register writes.
module tb_ide_xfer_ctrl;
    import ide_pkg::*;

    localparam int STB = 2;

    logic        clk = 1'b0;
    logic        arst;
    logic        req_valid, req_ready, req_write;
    logic [23:0] req_lba;
    logic [8:0]  buf_addr;
    logic        buf_we;
    logic [7:0]  buf_wdata, buf_rdata;
    logic        ide_ce_n, ide_oe_n, ide_we_n;
    logic [2:0]  ide_address;
    logic [7:0]  ide_data_out, ide_data_in;
    logic        busy, done, error;
    logic [7:0]  last_status;
    ide_dbg_t    dbg;

    always #5 clk = ~clk;

    ide_xfer_ctrl #(.STROBE_CYCLES(STB), .POLL_TIMEOUT(4), .SECTOR_BYTES(512)) dut (
        .clk(clk), .arst(arst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_lba(req_lba),
        .buf_addr(buf_addr), .buf_we(buf_we), .buf_wdata(buf_wdata), .buf_rdata(buf_rdata),
        .ide_ce_n(ide_ce_n), .ide_oe_n(ide_oe_n), .ide_we_n(ide_we_n),
        .ide_address(ide_address), .ide_data_out(ide_data_out), .ide_data_in(ide_data_in),
        .busy(busy), .done(done), .error(error), .last_status(last_status), .dbg(dbg)
    );

    // Local buffer: fill_mode 1 clears, 2 loads 0xA5^addr.
    logic [7:0] mem [0:511];
    logic [1:0] fill_mode;
    always @(posedge clk) begin
        if (fill_mode == 2'd1) begin
            for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
        end else if (fill_mode == 2'd2) begin
            for (int i = 0; i < 512; i++) mem[i] <= 8'hA5 ^ 8'(i);
        end else if (buf_we) begin
            mem[buf_addr] <= buf_wdata;
        end
        buf_rdata <= mem[buf_addr];
    end

    // ide device model: status script for reg7, bytes 1,2,3.. for reg0.
    logic [7:0] status_arr [0:7];
    int         status_len;
    int         cmd_polls, cmd_bytes, wr_bytes;
    logic [2:0] sidx;
    always_comb begin
        sidx = (cmd_polls < status_len) ? 3'(cmd_polls) : 3'(status_len - 1);
        if (ide_address == 3'd7) ide_data_in = status_arr[sidx];
        else                     ide_data_in = 8'(cmd_bytes + 1);
    end

    logic [10:0] exp_q [$];
    int n_tests, n_fail, done_cnt, oe_low, we_low, d0;
    logic prev_oe, prev_we;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_write();
        logic [10:0] got, exp_w;
        got = {ide_address, ide_data_out};
        exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : ~got;
        n_tests++;
        assert (got === exp_w) else begin
            n_fail++;
            $error("FAIL sb_write: got reg%0d=%02h expected reg%0d=%02h", got[10:8], got[7:0], exp_w[10:8], exp_w[7:0]);
        end
        if (ide_address == 3'd7) begin
            cmd_polls = 0;
            cmd_bytes = 0;
            wr_bytes  = 0;
        end else if (ide_address == 3'd0) begin
            wr_bytes++;
        end
    endtask

    // One cycle: wait for the falling edge and observe the bus there.
    task automatic tick();
        @(negedge clk);
        if (done) done_cnt++;
        if (arst) begin
            oe_low = 0; we_low = 0; prev_oe = 1'b1; prev_we = 1'b1;
        end else begin
            if (prev_we && !ide_we_n) check_write();
            if (!ide_oe_n) oe_low++;
            else if (!prev_oe) begin
                check("oe_width", 32'(oe_low), 32'(STB));
                if (ide_address == 3'd7) cmd_polls++;
                else if (ide_address == 3'd0) cmd_bytes++;
                oe_low = 0;
            end
            if (!ide_we_n) we_low++;
            else if (!prev_we) begin
                check("we_width", 32'(we_low), 32'(STB));
                we_low = 0;
            end
            prev_oe = ide_oe_n;
            prev_we = ide_we_n;
        end
    endtask

    task automatic set_status(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
                              input logic [7:0] s3, input int len);
        status_arr[0] = s0; status_arr[1] = s1; status_arr[2] = s2; status_arr[3] = s3;
        status_len = len;
    endtask

    task automatic push_tf(input logic [23:0] lba, input logic wr);
        exp_q.push_back({3'd2, 8'h01});
        exp_q.push_back({3'd3, lba[7:0]});
        exp_q.push_back({3'd4, lba[15:8]});
        exp_q.push_back({3'd5, lba[23:16]});
        exp_q.push_back({3'd6, 8'hE0});
        exp_q.push_back({3'd7, wr ? 8'h30 : 8'h20});
    endtask

    task automatic clear_buf();
        fill_mode = 2'd1; tick(); fill_mode = 2'd0;
    endtask

    task automatic issue(input logic wr, input logic [23:0] lba, input string tag);
        d0 = done_cnt;
        req_valid = 1'b1; req_write = wr; req_lba = lba;
        tick();
        req_valid = 1'b0;
        check({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy && k < 4000) begin tick(); k++; end
        check({tag, "_timeout"}, 32'(busy), 32'd0);
    endtask

    initial begin
        n_tests = 0; n_fail = 0; done_cnt = 0; oe_low = 0; we_low = 0;
        prev_oe = 1'b1; prev_we = 1'b1;
        cmd_polls = 0; cmd_bytes = 0; wr_bytes = 0;
        arst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_lba = 24'd0; fill_mode = 2'd0;
        set_status(8'h08, 8'h08, 8'h08, 8'h08, 1);
        status_arr[4] = 8'h00; status_arr[5] = 8'h00; status_arr[6] = 8'h00; status_arr[7] = 8'h00;
        repeat (3) tick();

        // Reset state
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_busy_done_err", {29'd0, busy, done, error}, 32'd0);
        check("rst_strobes", {29'd0, ide_ce_n, ide_oe_n, ide_we_n}, 32'd7);
        check("rst_addr_data", {21'd0, ide_address, ide_data_out}, 32'd0);
        check("rst_buf", {22'd0, buf_we, buf_addr}, 32'd0);
        check("rst_last_status", 32'(last_status), 32'd0);
        check("rst_state", 32'(dbg.ctrl), 32'(S_IDLE));
        arst = 1'b0;
        tick();

        // Read lba 0x000102, status 0x08, bytes 1..512
        clear_buf();
        push_tf(24'h000102, 1'b0);
        issue(1'b0, 24'h000102, "rd");
        wait_idle("rd");
        check("rd_sb_empty", 32'(exp_q.size()), 32'd0);
        check("rd_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("rd_error", 32'(error), 32'd0);
        check("rd_polls", 32'(cmd_polls), 32'd1);
        check("rd_bytes", 32'(cmd_bytes), 32'd512);
        check("rd_buf0", 32'(mem[0]), 32'h01);
        check("rd_buf255", 32'(mem[255]), 32'h00);
        check("rd_buf511", 32'(mem[511]), 32'h00);
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 512; i++) if (mem[i] !== 8'(i + 1)) bad++;
            check("rd_buf_all", 32'(bad), 32'd0);
        end
        check("rd_last_status", 32'(last_status), 32'h08);

        // Write lba 0xABCDEF from 0xA5^addr; a request during busy is ignored
        fill_mode = 2'd2; tick(); fill_mode = 2'd0;
        push_tf(24'hABCDEF, 1'b1);
        for (int i = 0; i < 512; i++) exp_q.push_back({3'd0, 8'hA5 ^ 8'(i)});
        issue(1'b1, 24'hABCDEF, "wr");
        req_valid = 1'b1; req_write = 1'b0;
        repeat (4) tick();
        check("wr_ready_while_busy", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
        wait_idle("wr");
        check("wr_sb_empty", 32'(exp_q.size()), 32'd0);
        check("wr_reg0_writes", 32'(wr_bytes), 32'd512);
        check("wr_no_reads", 32'(cmd_bytes), 32'd0);
        check("wr_done_pulses", 32'(done_cnt - d0), 32'd1);
        repeat (5) tick();
        check("wr_no_queued_req", 32'(busy), 32'd0);

        // BSY for three polls, then DRQ
        clear_buf();
        set_status(8'h80, 8'h80, 8'h80, 8'h08, 4);
        push_tf(24'h000005, 1'b0);
        issue(1'b0, 24'h000005, "bsy");
        wait_idle("bsy");
        check("bsy_polls", 32'(cmd_polls), 32'd4);
        check("bsy_last_status", 32'(last_status), 32'h08);
        check("bsy_bytes", 32'(cmd_bytes), 32'd512);
        check("bsy_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("bsy_buf0", 32'(mem[0]), 32'h01);

        // ERR|DRQ on first poll: ERR wins
        set_status(8'h09, 8'h09, 8'h09, 8'h09, 1);
        push_tf(24'h123456, 1'b0);
        issue(1'b0, 24'h123456, "err");
        wait_idle("err");
        check("err_flag", 32'(error), 32'd1);
        check("err_polls", 32'(cmd_polls), 32'd1);
        check("err_no_data", 32'(cmd_bytes), 32'd0);
        check("err_no_done", 32'(done_cnt - d0), 32'd0);
        check("err_last_status", 32'(last_status), 32'h09);
        check("err_sb_empty", 32'(exp_q.size()), 32'd0);
        check("err_state", 32'(dbg.ctrl), 32'(S_IDLE));
        set_status(8'h08, 8'h08, 8'h08, 8'h08, 1);
        push_tf(24'h000777, 1'b0);
        issue(1'b0, 24'h000777, "errclr");
        check("errclr_cleared", 32'(error), 32'd0);
        wait_idle("errclr");
        check("errclr_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("errclr_error", 32'(error), 32'd0);

        // BSY stuck: POLL_TIMEOUT=4 reads then error
        set_status(8'h80, 8'h80, 8'h80, 8'h80, 1);
        push_tf(24'h00BEEF, 1'b0);
        issue(1'b0, 24'h00BEEF, "tmo");
        wait_idle("tmo");
        check("tmo_polls", 32'(cmd_polls), 32'd4);
        check("tmo_error", 32'(error), 32'd1);
        check("tmo_no_data", 32'(cmd_bytes), 32'd0);
        check("tmo_no_done", 32'(done_cnt - d0), 32'd0);
        check("tmo_last_status", 32'(last_status), 32'h80);

        // Reset in the middle of XFER, then a clean transfer
        set_status(8'h08, 8'h08, 8'h08, 8'h08, 1);
        push_tf(24'h000042, 1'b0);
        issue(1'b0, 24'h000042, "abort");
        begin
            int k;
            k = 0;
            while (cmd_bytes < 100 && k < 4000) begin tick(); k++; end
        end
        check("abort_reached_byte100", 32'(cmd_bytes >= 100), 32'd1);
        d0 = done_cnt;
        arst = 1'b1;
        tick();
        check("abort_strobes", {29'd0, ide_ce_n, ide_oe_n, ide_we_n}, 32'd7);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(req_ready), 32'd1);
        check("abort_buf_we", 32'(buf_we), 32'd0);
        tick();
        arst = 1'b0;
        tick();
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check("abort_sb_empty", 32'(exp_q.size()), 32'd0);
        clear_buf();
        push_tf(24'h000100, 1'b0);
        issue(1'b0, 24'h000100, "post");
        wait_idle("post");
        check("post_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("post_bytes", 32'(cmd_bytes), 32'd512);
        check("post_buf100", 32'(mem[100]), 32'd101);
        check("post_buf511", 32'(mem[511]), 32'h00);
        check("post_error", 32'(error), 32'd0);
        check("post_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
